age_ordered_rs: RTL and testbench
=================================

// Module: age_ordered_rs
// PURPOSE
//  Next-gen single-issue reservation station for one execution unit (EU), between dispatch and the EU.
//  - Holds renamed uops until both sources are ready; NUM_CDB broadcast buses wake sources in parallel.
//  - Issue is oldest-first by ROB age, not lowest slot index.
//  - Branch recovery is selective: only uops younger than the mispredicted branch are squashed.
// PARAMETERS
//  PREG_WIDTH  7   physical register index width; preg 0 is hardwired zero
//  ROB_WIDTH   4   ROB tag width; age = (tag - i_rob_head) mod 2**ROB_WIDTH
//  RS_SIZE     8   number of entries (>=2)
//  NUM_CDB     2   number of wakeup/broadcast ports
//  PAYLOAD_W   69  opaque uop payload width {pc[31:0], imm[31:0], alu_op[3:0], alusrc}
// PORTS
//  clk              in   1                     clock
//  reset            in   1                     synchronous, active-high
//  i_alloc_valid    in   1                     dispatch presents a uop
//  o_alloc_ready    out  1                     at least one free entry (= !o_full)
//  i_prs1/i_prs2    in   PREG_WIDTH            source pregs
//  i_rs1_ready/i_rs2_ready in 1                source ready at dispatch
//  i_prd            in   PREG_WIDTH            destination preg
//  i_rob_tag        in   ROB_WIDTH             ROB tag of the uop
//  i_payload        in   PAYLOAD_W             carried unmodified to issue
//  i_cdb_valid      in   NUM_CDB               per-port broadcast valid
//  i_cdb_prd        in   NUM_CDB*PREG_WIDTH    per-port broadcast preg; port k = [k*PREG_WIDTH +: PREG_WIDTH]
//  i_rob_head       in   ROB_WIDTH             tag of the oldest in-flight uop
//  i_flush_valid    in   1                     mispredict: squash entries younger than i_flush_rob_tag
//  i_flush_rob_tag  in   ROB_WIDTH             tag of the mispredicted branch
//  i_flush_all      in   1                     squash every entry
//  i_eu_ready       in   1                     EU accepts an issue this cycle
//  o_issue_valid    out  1                     a ready entry is presented
//  o_issue_prs1/_prs2/_prd out PREG_WIDTH      fields of the selected entry
//  o_issue_rob_tag  out  ROB_WIDTH             tag of the selected entry
//  o_issue_payload  out  PAYLOAD_W             payload of the selected entry
//  o_full           out  1                     all RS_SIZE entries valid
//  o_count          out  $clog2(RS_SIZE+1)     number of valid entries
// BEHAVIOUR
//  Reset: all entries invalid. o_issue_valid=0, all issue fields=0, o_full=0, o_count=0, o_alloc_ready=1.
//  Allocation: fires when i_alloc_valid && o_alloc_ready.
//  - Writes the lowest-index free entry, judged on pre-cycle state.
//  - A slot freed by issue this cycle is not reused until the next cycle.
//  - Source readiness at allocation: rsN_ready = i_rsN_ready | (i_prsN==0) | (any port k: cdb_valid[k] && cdb_prd[k]==i_prsN && i_prsN!=0).
//  Wakeup: for each valid entry and port k, a source matching cdb_prd[k] (!=0) sets its ready flag at the clock edge.
//  - An entry woken in cycle N can issue in cycle N+1; there is no same-cycle bypass to issue.
//  - Both sources may wake from different ports in the same cycle.
//  Issue select: combinational, among entries with valid && rs1_ready && rs2_ready.
//  - Picks minimum age (tag - i_rob_head, ROB_WIDTH-bit wrap); ties are impossible since tags are unique.
//  - o_issue_valid = candidate exists. Fields are 0 when !o_issue_valid.
//  - Fire = o_issue_valid && i_eu_ready: the entry is invalidated and its ready flags cleared at the edge.
//  - Outputs may change while i_eu_ready=0 if an older entry becomes ready.
//  o_full, o_count, o_alloc_ready are derived combinationally from registered valid bits only.
//  Flush priority: reset > i_flush_all > i_flush_valid > normal operation.
//  - i_flush_all: every entry is invalidated; a same-cycle alloc and issue fire are dropped.
//  - i_flush_valid: every entry with age > age(i_flush_rob_tag) is invalidated; the branch entry and older entries are kept.
//  - With i_flush_valid, the same-cycle allocation is dropped.
//  - With i_flush_valid, a same-cycle issue fire still retires only if the issued entry is not squashed.
//  - With i_flush_valid, wakeup still applies to surviving entries.
//  Wrap: age arithmetic is modulo 2**ROB_WIDTH; correct as long as in-flight count < 2**ROB_WIDTH.
//  Full: allocation is ignored while o_full=1, even with a same-cycle issue (1-cycle bubble, by design).
// TESTING
//  1. Reset, alloc prs1=5 (not ready), prs2=0 -> o_issue_valid=0; cdb0 prd=5 -> o_issue_valid=1 next cycle, eu_ready=1 -> o_count 1->0.
//  2. head=14; alloc tags 1 into slot0, then 15 into slot1, both ready -> first issue is tag 15 (age 1), then tag 1 (age 3).
//  3. Alloc 8 uops -> o_full=1, o_alloc_ready=0; 9th i_alloc_valid ignored -> o_count stays 8.
//  4. head=0, entries tags 2,5,7; i_flush_valid tag=5 -> tags 2,5 remain, o_count=2; same-cycle alloc tag 6 dropped.
//  5. cdb0 prd=9 and cdb1 prd=10 same cycle, entry prs1=9/prs2=10 -> issues next cycle; alloc prs1=11 while cdb1 prd=11 -> stored ready.
//  6. Entry ready, eu_ready=0 for 3 cycles -> fields held stable; i_flush_all -> o_issue_valid=0, o_count=0 next cycle.

Source files
------------

// File: rtl/age_ordered_rs.sv
// Age-ordered reservation station for one execution unit.
// Wakes sources from several broadcast buses and issues the oldest ready uop first.
module age_ordered_rs #(
    parameter int PREG_WIDTH = 7,
    parameter int ROB_WIDTH  = 4,
    parameter int RS_SIZE    = 8,
    parameter int NUM_CDB    = 2,
    parameter int PAYLOAD_W  = 69,
    parameter int CNT_W      = $clog2(RS_SIZE + 1),
    parameter int IDX_W      = $clog2(RS_SIZE)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_alloc_valid,
    output logic                          o_alloc_ready,
    input  logic [PREG_WIDTH-1:0]         i_prs1,
    input  logic [PREG_WIDTH-1:0]         i_prs2,
    input  logic                          i_rs1_ready,
    input  logic                          i_rs2_ready,
    input  logic [PREG_WIDTH-1:0]         i_prd,
    input  logic [ROB_WIDTH-1:0]          i_rob_tag,
    input  logic [PAYLOAD_W-1:0]          i_payload,
    input  logic [NUM_CDB-1:0]            i_cdb_valid,
    input  logic [NUM_CDB*PREG_WIDTH-1:0] i_cdb_prd,
    input  logic [ROB_WIDTH-1:0]          i_rob_head,
    input  logic                          i_flush_valid,
    input  logic [ROB_WIDTH-1:0]          i_flush_rob_tag,
    input  logic                          i_flush_all,
    input  logic                          i_eu_ready,
    output logic                          o_issue_valid,
    output logic [PREG_WIDTH-1:0]         o_issue_prs1,
    output logic [PREG_WIDTH-1:0]         o_issue_prs2,
    output logic [PREG_WIDTH-1:0]         o_issue_prd,
    output logic [ROB_WIDTH-1:0]          o_issue_rob_tag,
    output logic [PAYLOAD_W-1:0]          o_issue_payload,
    output logic                          o_full,
    output logic [CNT_W-1:0]              o_count
);

    logic                  valid   [RS_SIZE];
    logic                  rdy1    [RS_SIZE];
    logic                  rdy2    [RS_SIZE];
    logic [PREG_WIDTH-1:0] prs1    [RS_SIZE];
    logic [PREG_WIDTH-1:0] prs2    [RS_SIZE];
    logic [PREG_WIDTH-1:0] prd     [RS_SIZE];
    logic [ROB_WIDTH-1:0]  tag     [RS_SIZE];
    logic [PAYLOAD_W-1:0]  payload [RS_SIZE];

    logic                  sel_found;
    logic [IDX_W-1:0]      sel_idx;
    logic [ROB_WIDTH-1:0]  sel_age;
    logic                  free_found;
    logic [IDX_W-1:0]      free_idx;
    logic [CNT_W-1:0]      count;
    logic                  alloc_fire;
    logic                  issue_fire;
    logic [ROB_WIDTH-1:0]  flush_age;
    logic                  new_rdy1;
    logic                  new_rdy2;

    function automatic logic [ROB_WIDTH-1:0] age_of(
        input logic [ROB_WIDTH-1:0] t,
        input logic [ROB_WIDTH-1:0] head
    );
        return t - head;
    endfunction

    // Preg 0 is hardwired zero, so it never matches a broadcast.
    function automatic logic woken(
        input logic [PREG_WIDTH-1:0]         p,
        input logic [NUM_CDB-1:0]            cv,
        input logic [NUM_CDB*PREG_WIDTH-1:0] cp
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (cv[k] && cp[k*PREG_WIDTH +: PREG_WIDTH] == p && p != '0)
                hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (valid[i] && rdy1[i] && rdy2[i]) begin
                if (!sel_found || age_of(tag[i], i_rob_head) < sel_age) begin
                    sel_found = 1'b1;
                    sel_idx   = IDX_W'(i);
                    sel_age   = age_of(tag[i], i_rob_head);
                end
            end
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        count      = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            count = count + CNT_W'(valid[i]);
        end
    end

    assign o_count       = count;
    assign o_full        = (count == CNT_W'(RS_SIZE));
    assign o_alloc_ready = !o_full;

    assign o_issue_valid   = sel_found;
    assign o_issue_prs1    = sel_found ? prs1[sel_idx]    : '0;
    assign o_issue_prs2    = sel_found ? prs2[sel_idx]    : '0;
    assign o_issue_prd     = sel_found ? prd[sel_idx]     : '0;
    assign o_issue_rob_tag = sel_found ? tag[sel_idx]     : '0;
    assign o_issue_payload = sel_found ? payload[sel_idx] : '0;

    assign issue_fire = sel_found && i_eu_ready;
    assign alloc_fire = i_alloc_valid && o_alloc_ready && free_found
                        && !i_flush_all && !i_flush_valid;
    assign flush_age  = age_of(i_flush_rob_tag, i_rob_head);

    assign new_rdy1 = i_rs1_ready || i_prs1 == '0
                      || woken(i_prs1, i_cdb_valid, i_cdb_prd);
    assign new_rdy2 = i_rs2_ready || i_prs2 == '0
                      || woken(i_prs2, i_cdb_valid, i_cdb_prd);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                valid[i] <= 1'b0;
                rdy1[i]  <= 1'b0;
                rdy2[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (valid[i]) begin
                    // Squash covers flush-all and younger-than-branch entries.
                    if (i_flush_all
                        || (i_flush_valid
                            && age_of(tag[i], i_rob_head) > flush_age)
                        || (issue_fire && sel_idx == IDX_W'(i))) begin
                        valid[i] <= 1'b0;
                        rdy1[i]  <= 1'b0;
                        rdy2[i]  <= 1'b0;
                    end else begin
                        if (woken(prs1[i], i_cdb_valid, i_cdb_prd))
                            rdy1[i] <= 1'b1;
                        if (woken(prs2[i], i_cdb_valid, i_cdb_prd))
                            rdy2[i] <= 1'b1;
                    end
                end else if (alloc_fire && free_idx == IDX_W'(i)) begin
                    valid[i]   <= 1'b1;
                    rdy1[i]    <= new_rdy1;
                    rdy2[i]    <= new_rdy2;
                    prs1[i]    <= i_prs1;
                    prs2[i]    <= i_prs2;
                    prd[i]     <= i_prd;
                    tag[i]     <= i_rob_tag;
                    payload[i] <= i_payload;
                end
            end
        end
    end

endmodule

// File: tb/tb_age_ordered_rs.sv
// Directed bench for age_ordered_rs.
// Expected issue order is queued at dispatch and checked at each issue.
module tb_age_ordered_rs;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_alloc_valid;
    logic        o_alloc_ready;
    logic [6:0]  i_prs1, i_prs2, i_prd;
    logic        i_rs1_ready, i_rs2_ready;
    logic [3:0]  i_rob_tag;
    logic [68:0] i_payload;
    logic [1:0]  i_cdb_valid;
    logic [13:0] i_cdb_prd;
    logic [3:0]  i_rob_head;
    logic        i_flush_valid;
    logic [3:0]  i_flush_rob_tag;
    logic        i_flush_all;
    logic        i_eu_ready;
    logic        o_issue_valid;
    logic [6:0]  o_issue_prs1, o_issue_prs2, o_issue_prd;
    logic [3:0]  o_issue_rob_tag;
    logic [68:0] o_issue_payload;
    logic        o_full;
    logic [3:0]  o_count;

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_q[$];
    logic [3:0] held;

    age_ordered_rs dut (
        .clk(clk), .reset(reset),
        .i_alloc_valid(i_alloc_valid), .o_alloc_ready(o_alloc_ready),
        .i_prs1(i_prs1), .i_prs2(i_prs2),
        .i_rs1_ready(i_rs1_ready), .i_rs2_ready(i_rs2_ready),
        .i_prd(i_prd), .i_rob_tag(i_rob_tag), .i_payload(i_payload),
        .i_cdb_valid(i_cdb_valid), .i_cdb_prd(i_cdb_prd),
        .i_rob_head(i_rob_head),
        .i_flush_valid(i_flush_valid), .i_flush_rob_tag(i_flush_rob_tag),
        .i_flush_all(i_flush_all), .i_eu_ready(i_eu_ready),
        .o_issue_valid(o_issue_valid),
        .o_issue_prs1(o_issue_prs1), .o_issue_prs2(o_issue_prs2),
        .o_issue_prd(o_issue_prd), .o_issue_rob_tag(o_issue_rob_tag),
        .o_issue_payload(o_issue_payload),
        .o_full(o_full), .o_count(o_count)
    );

    always #5 clk = ~clk;

    function automatic logic [68:0] pl(input logic [3:0] t);
        return {32'h1000 + 32'(t), 32'hA0 + 32'(t), t, t[0]};
    endfunction

    task automatic chk(input string name, input logic [68:0] obs,
                       input logic [68:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_alloc_valid = 0; i_rs1_ready = 0; i_rs2_ready = 0;
        i_prs1 = 0; i_prs2 = 0; i_prd = 0; i_rob_tag = 0; i_payload = 0;
        i_cdb_valid = 0; i_cdb_prd = 0;
        i_flush_valid = 0; i_flush_rob_tag = 0; i_flush_all = 0;
        i_eu_ready = 0;
    endtask

    task automatic alloc(input logic [6:0] p1, input logic r1,
                         input logic [6:0] p2, input logic r2,
                         input logic [3:0] t);
        i_alloc_valid = 1;
        i_prs1 = p1; i_rs1_ready = r1;
        i_prs2 = p2; i_rs2_ready = r2;
        i_prd = 7'(t) + 7'd20; i_rob_tag = t; i_payload = pl(t);
    endtask

    // Fire one issue with the EU ready and compare against the queue head.
    task automatic issue_one(input string name);
        logic [3:0] e;
        i_eu_ready = 1;
        #1;
        chk({name, "_valid"}, 69'(o_issue_valid), 69'(1));
        if (exp_q.size() == 0) begin
            chk({name, "_queue"}, 69'(0), 69'(1));
        end else begin
            e = exp_q.pop_front();
            chk({name, "_tag"}, 69'(o_issue_rob_tag), 69'(e));
            chk({name, "_prd"}, 69'(o_issue_prd), 69'(7'(e) + 7'd20));
            chk({name, "_payload"}, o_issue_payload, pl(e));
        end
        tick();
        i_eu_ready = 0;
    endtask

    initial begin
        idle();
        i_rob_head = 0;
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        chk("rst_valid", 69'(o_issue_valid), 69'(0));
        chk("rst_count", 69'(o_count), 69'(0));
        chk("rst_full", 69'(o_full), 69'(0));
        chk("rst_aready", 69'(o_alloc_ready), 69'(1));
        chk("rst_tag", 69'(o_issue_rob_tag), 69'(0));
        chk("rst_payload", o_issue_payload, 69'(0));

        // Single uop woken by a broadcast
        alloc(7'd5, 0, 7'd0, 0, 4'd3);
        exp_q.push_back(4'd3);
        tick(); idle();
        chk("t1_count1", 69'(o_count), 69'(1));
        chk("t1_notready", 69'(o_issue_valid), 69'(0));
        i_cdb_valid = 2'b01; i_cdb_prd = 14'd5;
        #1;
        chk("t1_no_bypass", 69'(o_issue_valid), 69'(0));
        tick(); idle();
        issue_one("t1_issue");
        chk("t1_count0", 69'(o_count), 69'(0));

        // Oldest-first across ROB wrap
        i_rob_head = 4'd14;
        alloc(7'd0, 1, 7'd0, 1, 4'd1);
        tick();
        alloc(7'd0, 1, 7'd0, 1, 4'd15);
        exp_q.push_back(4'd15);
        exp_q.push_back(4'd1);
        tick(); idle();
        issue_one("t2_first");
        issue_one("t2_second");
        chk("t2_count0", 69'(o_count), 69'(0));

        // Fill to capacity
        i_rob_head = 0;
        for (int i = 0; i < 8; i++) begin
            alloc(7'd30, 0, 7'd0, 1, 4'(i));
            tick();
        end
        idle();
        chk("t3_full", 69'(o_full), 69'(1));
        chk("t3_aready", 69'(o_alloc_ready), 69'(0));
        chk("t3_count8", 69'(o_count), 69'(8));
        alloc(7'd0, 1, 7'd0, 1, 4'd8);
        tick(); idle();
        chk("t3_ninth", 69'(o_count), 69'(8));
        chk("t3_none_ready", 69'(o_issue_valid), 69'(0));
        i_flush_all = 1;
        tick(); idle();
        chk("t3_flushall", 69'(o_count), 69'(0));

        // Selective flush keeps the branch and older entries
        alloc(7'd30, 0, 7'd0, 1, 4'd2); tick();
        alloc(7'd30, 0, 7'd0, 1, 4'd5); tick();
        alloc(7'd30, 0, 7'd0, 1, 4'd7); tick();
        idle();
        chk("t4_count3", 69'(o_count), 69'(3));
        i_flush_valid = 1; i_flush_rob_tag = 4'd5;
        alloc(7'd0, 1, 7'd0, 1, 4'd6);
        tick(); idle();
        chk("t4_count2", 69'(o_count), 69'(2));
        chk("t4_idle", 69'(o_issue_valid), 69'(0));
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd5);
        i_cdb_valid = 2'b10; i_cdb_prd = {7'd30, 7'd0};
        tick(); idle();
        issue_one("t4_a");
        issue_one("t4_b");
        chk("t4_empty", 69'(o_count), 69'(0));

        // Dual-port wakeup and wakeup during allocation
        alloc(7'd9, 0, 7'd10, 0, 4'd4);
        exp_q.push_back(4'd4);
        tick(); idle();
        i_cdb_valid = 2'b11; i_cdb_prd = {7'd10, 7'd9};
        #1;
        chk("t5_wait", 69'(o_issue_valid), 69'(0));
        tick(); idle();
        issue_one("t5_dual");
        alloc(7'd11, 0, 7'd0, 0, 4'd5);
        i_cdb_valid = 2'b10; i_cdb_prd = {7'd11, 7'd0};
        exp_q.push_back(4'd5);
        tick(); idle();
        issue_one("t5_alloc_wake");

        // Hold while the EU stalls, then flush everything
        alloc(7'd0, 1, 7'd0, 1, 4'd9);
        tick(); idle();
        held = o_issue_rob_tag;
        chk("t6_tag", 69'(held), 69'(9));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_hold_valid", 69'(o_issue_valid), 69'(1));
            chk("t6_hold_tag", 69'(o_issue_rob_tag), 69'(9));
            chk("t6_hold_pl", o_issue_payload, pl(4'd9));
        end
        i_flush_all = 1; i_eu_ready = 1;
        tick(); idle();
        chk("t6_valid0", 69'(o_issue_valid), 69'(0));
        chk("t6_count0", 69'(o_count), 69'(0));
        chk("t6_tag0", 69'(o_issue_rob_tag), 69'(0));
        chk("sb_drained", 69'(exp_q.size()), 69'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
